// File: rtl/leon_issue_sequencer_pkg.sv
// Shared types for the LEON issue sequencer: NOP encoding, FSM states, FIFO entry layout.
// Optional flush input is enabled by defining LEON_ISSUE_FLUSH_EN.
package leon_issue_sequencer_pkg;

   localparam int          ISS_GAP_W = 4;
   localparam logic [31:0] NOP_INST  = 32'h0100_0000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      PAD
   } iss_state_t;

   typedef struct packed {
      logic [31:0]          inst;
      logic [ISS_GAP_W-1:0] gap;
   } iss_entry_t;

   // Pad count actually applied: never below the configured floor.
   function automatic logic [ISS_GAP_W-1:0] eff_gap_f(input logic [ISS_GAP_W-1:0] gap,
                                                       input logic [ISS_GAP_W-1:0] min_gap);
      return (gap < min_gap) ? min_gap : gap;
   endfunction

endpackage

// File: rtl/leon_issue_sequencer_iss_fifo.sv
// Synchronous DEPTH-entry FIFO of issue entries with synchronous active-low reset and clear.
// Push is ignored when full, pop is ignored when empty; both may occur on the same edge.
module iss_fifo
   import leon_issue_sequencer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  iss_entry_t               wr_entry,
   output iss_entry_t               rd_entry,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   iss_entry_t       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full && rst && !clear;
   assign do_pop  = pop && !empty && rst && !clear;

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

   assign rd_entry = mem[rd_ptr];
   assign full     = (cnt == (AW+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;

endmodule

// File: rtl/leon_issue_sequencer.sv
// Issue sequencer: queues instruction words and presents one word per un-held cycle,
// padding each with NOPs. Define LEON_ISSUE_FLUSH_EN to add the flush input.
module leon_issue_sequencer
   import leon_issue_sequencer_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int GAP_W   = ISS_GAP_W,
   parameter int MIN_GAP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [GAP_W-1:0] in_gap,
   input  logic             hold,
   output logic [31:0]      issue_inst,
   output logic             issue_valid,
   output logic             busy,
   output logic [15:0]      issued_cnt
`ifdef LEON_ISSUE_FLUSH_EN
   ,
   input  logic             flush
`endif
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("leon_issue_sequencer: DEPTH must be a power of two and at least 2");
   end
   if (GAP_W != ISS_GAP_W) begin : g_bad_gap_w
      $error("leon_issue_sequencer: GAP_W must match the package entry layout");
   end
   if (MIN_GAP < 0 || MIN_GAP > (2 ** GAP_W) - 1) begin : g_bad_min_gap
      $error("leon_issue_sequencer: MIN_GAP must fit in GAP_W bits");
   end

   iss_state_t              state;
   logic [GAP_W-1:0]        pad_cnt;
   logic                    ready_q;
   logic                    flush_i;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic                    push;
   logic                    pop;
   iss_entry_t              wr_entry;
   iss_entry_t              rd_entry;

`ifdef LEON_ISSUE_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   // Ready only reflects fullness; a pop on the same edge is not anticipated.
   assign in_ready = rst && ready_q && !fifo_full;
   assign push     = in_valid && in_ready && !flush_i;
   assign pop      = rst && !flush_i && !hold && (pad_cnt == '0) && !fifo_empty;

   assign wr_entry.inst = in_inst;
   assign wr_entry.gap  = eff_gap_f(in_gap, ISS_GAP_W'(MIN_GAP));

   iss_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush_i),
      .push     (push),
      .pop      (pop),
      .wr_entry (wr_entry),
      .rd_entry (rd_entry),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         pad_cnt     <= '0;
         issue_inst  <= NOP_INST;
         issue_valid <= 1'b0;
         issued_cnt  <= '0;
         ready_q     <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (flush_i) begin
            state       <= IDLE;
            pad_cnt     <= '0;
            issue_inst  <= NOP_INST;
            issue_valid <= 1'b0;
         end else if (!hold) begin
            if (pad_cnt != '0) begin
               state       <= PAD;
               pad_cnt     <= pad_cnt - GAP_W'(1);
               issue_inst  <= NOP_INST;
               issue_valid <= 1'b0;
            end else if (!fifo_empty) begin
               state       <= ISSUE;
               pad_cnt     <= rd_entry.gap;
               issue_inst  <= rd_entry.inst;
               issue_valid <= 1'b1;
               issued_cnt  <= issued_cnt + 16'd1;
            end else begin
               state       <= IDLE;
               issue_inst  <= NOP_INST;
               issue_valid <= 1'b0;
            end
         end
      end
   end

   assign busy = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_leon_issue_sequencer.sv
// Self-checking bench: queue-based reference model checked every cycle, directed scenarios,
// randomized traffic, and a second back-to-back instance for the issued_cnt wrap.
module tb_leon_issue_sequencer;

   localparam int          DEPTH = 8;
   localparam int          MIN_G = 1;
   localparam logic [31:0] NOP   = 32'h0100_0000;

   logic        clk;
   logic        rst, in_valid, hold, flush;
   logic [31:0] in_inst;
   logic [3:0]  in_gap;
   logic        in_ready, issue_valid, busy;
   logic [31:0] issue_inst;
   logic [15:0] issued_cnt;

   logic        w_rst, w_valid, w_hold;
   logic [31:0] w_inst;
   logic        w_ready, w_issue_valid, w_busy;
   logic [31:0] w_issue_inst;
   logic [15:0] w_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   leon_issue_sequencer #(.DEPTH(DEPTH), .GAP_W(4), .MIN_GAP(MIN_G)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_gap(in_gap), .hold(hold), .issue_inst(issue_inst), .issue_valid(issue_valid),
      .busy(busy), .issued_cnt(issued_cnt)
`ifdef LEON_ISSUE_FLUSH_EN
      , .flush(flush)
`endif
   );

   leon_issue_sequencer #(.DEPTH(DEPTH), .GAP_W(4), .MIN_GAP(0)) dut_wrap (
      .clk(clk), .rst(w_rst), .in_valid(w_valid), .in_ready(w_ready), .in_inst(w_inst),
      .in_gap(4'd0), .hold(w_hold), .issue_inst(w_issue_inst), .issue_valid(w_issue_valid),
      .busy(w_busy), .issued_cnt(w_cnt)
`ifdef LEON_ISSUE_FLUSH_EN
      , .flush(1'b0)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference model: queue of pending words, remaining pad NOPs, and last issued word.
   logic [31:0] q_inst[$];
   int          q_gap[$];
   int          m_pad    = 0;
   logic [31:0] m_inst   = NOP;
   bit          m_valid  = 0;
   int          m_cnt    = 0;
   bit          m_active = 0;
   bit          m_rdy    = 0;
   bit          m_on     = 0;

   always @(posedge clk) begin
      bit push_ok;
      if (!rst) begin
         q_inst.delete(); q_gap.delete();
         m_pad = 0; m_inst = NOP; m_valid = 0; m_cnt = 0; m_active = 0; m_rdy = 0; m_on = 1;
      end else begin
         push_ok = in_valid && m_rdy && (q_inst.size() < DEPTH) && !flush;
         if (flush) begin
            q_inst.delete(); q_gap.delete();
            m_pad = 0; m_inst = NOP; m_valid = 0; m_active = 0;
         end else if (!hold) begin
            if (m_pad > 0) begin
               m_inst = NOP; m_valid = 0; m_pad--; m_active = 1;
            end else if (q_inst.size() > 0) begin
               m_inst = q_inst.pop_front(); m_pad = q_gap.pop_front();
               m_valid = 1; m_cnt = (m_cnt + 1) % 65536; m_active = 1;
            end else begin
               m_inst = NOP; m_valid = 0; m_active = 0;
            end
         end
         if (push_ok) begin
            q_inst.push_back(in_inst);
            q_gap.push_back((int'(in_gap) < MIN_G) ? MIN_G : int'(in_gap));
         end
         m_rdy = 1;
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         check("model_inst",  issue_inst,  m_inst);
         check("model_valid", issue_valid, m_valid);
         check("model_cnt",   issued_cnt,  32'(m_cnt));
         check("model_busy",  busy,        m_active || (q_inst.size() > 0));
         check("model_ready", in_ready,    rst && m_rdy && (q_inst.size() < DEPTH));
      end
   end

   task automatic main_seq();
      logic [31:0] got[$];
      bit          vpat[5];
      logic [31:0] ipat[5];
      rst = 0; in_valid = 0; in_inst = 0; in_gap = 0; hold = 0; flush = 0;
      repeat (3) tick();
      rst = 1;
      tick();
      @(negedge clk);
      check("post_reset_ready", in_ready, 1);

      // Reset in the middle of a stream of queued instructions.
      in_valid = 1; in_gap = 3;
      for (int i = 0; i < 3; i++) begin in_inst = 32'h1000_0000 + i; tick(); end
      in_valid = 0;
      repeat (2) tick();
      rst = 0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_inst", issue_inst, 32'h0100_0000);
      check("rst_valid", issue_valid, 0);
      check("rst_cnt", issued_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 0);
      rst = 1;
      tick();
      @(negedge clk);
      check("rst_release_ready", in_ready, 1);

      // Single issue with four pad NOPs.
      in_valid = 1; in_inst = 32'h8200_4002; in_gap = 4;
      tick();
      in_valid = 0;
      @(negedge clk);
      check("single_latency_valid", issue_valid, 0);
      tick();
      @(negedge clk);
      check("single_inst", issue_inst, 32'h8200_4002);
      check("single_valid", issue_valid, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         check("single_pad_valid", issue_valid, 0);
         check("single_pad_busy", busy, 1);
      end
      tick();
      @(negedge clk);
      check("single_idle_busy", busy, 0);
      check("single_cnt", issued_cnt, 1);

      // Gap 0 is raised to the one-NOP floor.
      in_valid = 1; in_gap = 0; in_inst = 32'h9000_0001;
      tick();
      in_inst = 32'h9000_0002;
      tick();
      in_valid = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vpat[i] = issue_valid; ipat[i] = issue_inst;
         tick();
      end
      check("mingap_v0", vpat[0], 1);
      check("mingap_v1", vpat[1], 0);
      check("mingap_v2", vpat[2], 1);
      check("mingap_v3", vpat[3], 0);
      check("mingap_v4", vpat[4], 0);
      check("mingap_i0", ipat[0], 32'h9000_0001);
      check("mingap_i2", ipat[2], 32'h9000_0002);
      check("mingap_cnt", issued_cnt, 3);

      // Fill under hold: ninth push must be refused.
      hold = 1; in_valid = 1; in_gap = 1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check("full_ready", in_ready, (i < 8) ? 1 : 0);
         tick();
         in_inst = 32'hA000_0000 + 32'(i);
      end
      in_valid = 0;
      @(negedge clk);
      check("full_ready_after", in_ready, 0);
      // in_inst was updated after each edge, so entry i was pushed with the value of push i-1;
      // redo with a clean, aligned fill.
      rst = 0; hold = 0; tick(); rst = 1; tick();
      hold = 1; in_valid = 1;
      for (int i = 0; i < 9; i++) begin
         in_inst = 32'hA000_0000 + 32'(i);
         tick();
      end
      in_valid = 0;
      @(negedge clk);
      check("full_ready_refill", in_ready, 0);
      hold = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         @(negedge clk);
         if (issue_valid) got.push_back(issue_inst);
      end
      check("full_count", got.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < got.size()) check("full_order", got[i], 32'hA000_0000 + 32'(i));
      end
      check("full_cnt", issued_cnt, 8);

      // Hold for five cycles while two pad NOPs remain.
      in_valid = 1; in_inst = 32'hB000_0000; in_gap = 4;
      tick();
      in_valid = 0;
      repeat (3) tick();
      hold = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         check("hold_inst", issue_inst, NOP);
         check("hold_valid", issue_valid, 0);
         check("hold_busy", busy, 1);
         check("hold_cnt", issued_cnt, 9);
      end
      hold = 0;
      tick(); @(negedge clk); check("hold_rel_pad1", busy, 1);
      tick(); @(negedge clk); check("hold_rel_pad2", busy, 1);
      tick(); @(negedge clk); check("hold_rel_idle", busy, 0);

`ifdef LEON_ISSUE_FLUSH_EN
      hold = 1; in_valid = 1; in_gap = 2;
      for (int i = 0; i < 3; i++) begin in_inst = 32'hC000_0000 + 32'(i); tick(); end
      flush = 1; in_inst = 32'hDEAD_0000;
      tick();
      flush = 0; in_valid = 0; hold = 0;
      @(negedge clk);
      check("flush_busy", busy, 0);
      check("flush_valid", issue_valid, 0);
      check("flush_ready", in_ready, 1);
      tick();
      @(negedge clk);
      check("flush_drop_valid", issue_valid, 0);
      check("flush_cnt_kept", issued_cnt, 9);
`endif

      // Randomized traffic; the model compare runs every cycle.
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 99) < 60);
         in_inst  = $urandom;
         in_gap   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
         hold     = ($urandom_range(0, 99) < 15);
         rst      = ($urandom_range(0, 299) != 0);
`ifdef LEON_ISSUE_FLUSH_EN
         flush    = ($urandom_range(0, 199) == 0);
`endif
         tick();
      end
      rst = 1; in_valid = 0; hold = 0; flush = 0;
      repeat (200) tick();
      @(negedge clk);
      check("drain_busy", busy, 0);
   endtask

   task automatic wrap_seq();
      int  seen = 0;
      int  cyc  = 0;
      bit  acc;
      w_rst = 0; w_valid = 0; w_inst = 0; w_hold = 0;
      repeat (3) tick();
      w_rst = 1; w_valid = 1;
      while (seen < 65536 && cyc < 70000) begin
         @(negedge clk);
         acc = w_valid && w_ready;
         if (cyc % 2048 == 100) check("wrap_b2b", w_issue_valid, 1);
         if (w_issue_valid) begin
            if (seen % 4096 == 0) begin
               check("wrap_inst", w_issue_inst, 32'(seen));
               check("wrap_cnt", w_cnt, 32'((seen + 1) % 65536));
            end
            if (seen == 65534) check("wrap_ffff", w_cnt, 32'h0000_FFFF);
            if (seen == 65535) check("wrap_to_zero", w_cnt, 32'h0000_0000);
            seen++;
         end
         @(posedge clk);
         #2;
         if (acc) w_inst = w_inst + 1;
         cyc++;
      end
      check("wrap_total", seen, 65536);
      w_valid = 0;
   endtask

   initial begin
      fork
         main_seq();
         wrap_seq();
      join
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
